// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer, the PC mux and the decoder.
package pipeline_ctrl_pkg;

    // Sequencer states; encoding 2'd3 is illegal and recovers to StBoot.
    typedef enum logic [1:0] {
        StBoot    = 2'd0,
        StRun     = 2'd1,
        StMemWait = 2'd2
    } state_e;

    // PC mux select codes.
    localparam logic [1:0] PcSelNext   = 2'b00;  // PC + 4
    localparam logic [1:0] PcSelTarget = 2'b01;  // EX branch/jump target
    localparam logic [1:0] PcSelReset  = 2'b10;  // RESET_PC
    localparam logic [1:0] PcSelHold   = 2'b11;  // keep current PC

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Load-use hazard detect: ID reads a register that a load in EX has not produced yet.
module pipeline_ctrl_hazard_unit (
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_wen,
    input  logic       ex_is_load,
    output logic       hazard
);

    // x0 is never a real producer, so a load to rd=0 cannot stall.
    always_comb begin
        hazard = ex_valid & ex_is_load & ex_reg_wen & (ex_rd != 5'd0) & id_valid
                 & ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: boot hold, load-use bubbles, redirect flush, MMIO wait,
// plus the cycle / instret performance counters.
module pipeline_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h4000_0000,
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_wen,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             ex_mem_req,
    input  logic             mem_ready,
    input  logic             cnt_reset,
    output logic [1:0]       pc_sel,
    output logic             if_stall,
    output logic             id_flush,
    output logic             ex_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    import pipeline_ctrl_pkg::*;

    localparam int unsigned BootW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int unsigned TmoW  = $clog2(MEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [BootW-1:0]   boot_q, boot_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic               mem_timeout_d;
    logic [CNT_W-1:0]   cycle_d, instret_d;
    logic               hazard;
    logic               tmo_hit;
    logic               flow;

    // The boot address itself is applied by the PC mux; only its select code is produced here.
    logic unused_reset_pc;
    assign unused_reset_pc = ^RESET_PC;

    pipeline_ctrl_hazard_unit u_hazard (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_reg_wen  (ex_reg_wen),
        .ex_is_load  (ex_is_load),
        .hazard      (hazard)
    );

    // Next-state and pipeline controls; `flow` marks cycles where EX may complete normally.
    always_comb begin
        state_d       = state_q;
        boot_d        = '0;
        tmo_d         = '0;
        mem_timeout_d = mem_timeout;
        pc_sel        = PcSelNext;
        if_stall      = 1'b0;
        id_flush      = 1'b0;
        ex_hold       = 1'b0;
        flow          = 1'b0;
        tmo_hit       = (tmo_q == TmoW'(MEM_TIMEOUT));

        unique case (state_q)
            StBoot: begin
                pc_sel   = PcSelReset;
                if_stall = 1'b1;
                id_flush = 1'b1;
                if (boot_q == BootW'(BOOT_CYCLES - 1)) begin
                    state_d = StRun;
                end else begin
                    boot_d = boot_q + BootW'(1);
                end
            end
            StRun: begin
                if (ex_mem_req & ~mem_ready) begin
                    pc_sel   = PcSelHold;
                    if_stall = 1'b1;
                    ex_hold  = 1'b1;
                    state_d  = StMemWait;
                end else begin
                    flow = 1'b1;
                end
            end
            StMemWait: begin
                if (mem_ready | tmo_hit) begin
                    // A timeout releases EX as if the slave had answered.
                    flow    = 1'b1;
                    state_d = StRun;
                    if (!mem_ready) begin
                        mem_timeout_d = 1'b1;
                    end
                end else begin
                    pc_sel   = PcSelHold;
                    if_stall = 1'b1;
                    ex_hold  = 1'b1;
                    tmo_d    = tmo_q + TmoW'(1);
                end
            end
            default: begin
                pc_sel   = PcSelReset;
                if_stall = 1'b1;
                id_flush = 1'b1;
                state_d  = StBoot;
            end
        endcase

        // Redirect kills the wrong-path ID, which makes any load-use hazard moot.
        if (flow) begin
            if (ex_redirect) begin
                pc_sel   = PcSelTarget;
                id_flush = 1'b1;
            end else if (hazard) begin
                pc_sel   = PcSelHold;
                if_stall = 1'b1;
                id_flush = 1'b1;
            end
        end
    end

    // Performance counters; cnt_reset wins over the increment.
    always_comb begin
        cycle_d   = cycle_cnt + CNT_W'(1);
        instret_d = instret_cnt;
        if (ex_valid & ~ex_hold & (state_q != StBoot)) begin
            instret_d = instret_cnt + CNT_W'(1);
        end
        if (cnt_reset) begin
            cycle_d   = '0;
            instret_d = '0;
        end
    end

    // State, counters and sticky timeout flag with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StBoot;
            boot_q      <= '0;
            tmo_q       <= '0;
            mem_timeout <= 1'b0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            state_q     <= state_d;
            boot_q      <= boot_d;
            tmo_q       <= tmo_d;
            mem_timeout <= mem_timeout_d;
            cycle_cnt   <= cycle_d;
            instret_cnt <= instret_d;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (counters narrowed to 8 bits to reach the wrap point).
module tb_pipeline_ctrl;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          ex_valid, ex_reg_wen, ex_is_load, ex_redirect, ex_mem_req;
    logic          mem_ready, cnt_reset;
    logic [1:0]    pc_sel;
    logic          if_stall, id_flush, ex_hold, mem_timeout;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .RESET_PC    (32'h4000_0000),
        .BOOT_CYCLES (4),
        .MEM_TIMEOUT (255),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_reg_wen  (ex_reg_wen),
        .ex_is_load  (ex_is_load),
        .ex_redirect (ex_redirect),
        .ex_mem_req  (ex_mem_req),
        .mem_ready   (mem_ready),
        .cnt_reset   (cnt_reset),
        .pc_sel      (pc_sel),
        .if_stall    (if_stall),
        .id_flush    (id_flush),
        .ex_hold     (ex_hold),
        .mem_timeout (mem_timeout),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    // Advance one clock; inputs change and outputs are sampled 2-3 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_valid = 0; ex_rd = 0; ex_reg_wen = 0; ex_is_load = 0; ex_redirect = 0;
        ex_mem_req = 0; mem_ready = 0; cnt_reset = 0;
    endtask

    // Zero both counters with no retire in flight.
    task automatic clr_cnt();
        idle();
        cnt_reset = 1;
        cyc();
        cnt_reset = 0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic u1, input logic u2);
        ex_valid = 1; ex_is_load = 1; ex_reg_wen = 1; ex_rd = rd;
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        repeat (3) cyc();
        #1;
        checks++; if (pc_sel !== 2'b10) begin errors++;
            $display("FAIL reset_pc_sel: got %b expected 10", pc_sel); end
        checks++; if (cycle_cnt !== 8'd0 || instret_cnt !== 8'd0) begin errors++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt); end
        checks++; if (mem_timeout !== 1'b0) begin errors++;
            $display("FAIL reset_mem_timeout: got %b expected 0", mem_timeout); end
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (pc_sel !== 2'b10 || {if_stall, id_flush, ex_hold} !== 3'b110) begin
                errors++;
                $display("FAIL boot_cycle_%0d: got pc_sel=%b stall/flush/hold=%b expected 10/110",
                         i, pc_sel, {if_stall, id_flush, ex_hold});
            end
            cyc();
        end
        #1;
        checks++; if (pc_sel !== 2'b00 || {if_stall, id_flush, ex_hold} !== 3'b000) begin errors++;
            $display("FAIL boot_exit: got pc_sel=%b flags=%b expected 00/000",
                     pc_sel, {if_stall, id_flush, ex_hold}); end
        checks++; if (cycle_cnt !== 8'd4 || instret_cnt !== 8'd0) begin errors++;
            $display("FAIL boot_cycle_cnt: got %0d/%0d expected 4/0", cycle_cnt, instret_cnt); end
    endtask

    task automatic test_load_use();
        clr_cnt();
        load_use(5'd5, 5'd5, 5'd7, 1, 1);
        #1;
        checks++; if (pc_sel !== 2'b11 || {if_stall, id_flush, ex_hold} !== 3'b110) begin errors++;
            $display("FAIL load_use_rs1: got pc_sel=%b flags=%b expected 11/110",
                     pc_sel, {if_stall, id_flush, ex_hold}); end
        cyc();
        ex_valid = 0; ex_is_load = 0;
        #1;
        checks++; if (pc_sel !== 2'b00 || {if_stall, id_flush} !== 2'b00) begin errors++;
            $display("FAIL load_use_single_bubble: got pc_sel=%b flags=%b expected 00/00",
                     pc_sel, {if_stall, id_flush}); end
        checks++; if (instret_cnt !== 8'd1) begin errors++;
            $display("FAIL load_use_instret: got %0d expected 1", instret_cnt); end
        cyc();
        load_use(5'd0, 5'd0, 5'd0, 1, 1);
        #1;
        checks++; if (pc_sel !== 2'b00 || {if_stall, id_flush} !== 2'b00) begin errors++;
            $display("FAIL load_use_x0: got pc_sel=%b flags=%b expected 00/00",
                     pc_sel, {if_stall, id_flush}); end
        cyc();
        load_use(5'd9, 5'd1, 5'd9, 1, 1);
        #1;
        checks++; if (pc_sel !== 2'b11 || {if_stall, id_flush} !== 2'b11) begin errors++;
            $display("FAIL load_use_rs2: got pc_sel=%b flags=%b expected 11/11",
                     pc_sel, {if_stall, id_flush}); end
        cyc();
        load_use(5'd9, 5'd1, 5'd9, 1, 0);
        #1;
        checks++; if (pc_sel !== 2'b00 || {if_stall, id_flush} !== 2'b00) begin errors++;
            $display("FAIL load_use_rs2_unused: got pc_sel=%b flags=%b expected 00/00",
                     pc_sel, {if_stall, id_flush}); end
        cyc();
        load_use(5'd3, 5'd3, 5'd0, 1, 0);
        ex_is_load = 0;
        #1;
        checks++; if (pc_sel !== 2'b00 || {if_stall, id_flush} !== 2'b00) begin errors++;
            $display("FAIL alu_no_stall: got pc_sel=%b flags=%b expected 00/00",
                     pc_sel, {if_stall, id_flush}); end
        cyc();
        idle();
        #1;
        checks++; if (instret_cnt !== 8'd5) begin errors++;
            $display("FAIL load_use_instret_total: got %0d expected 5", instret_cnt); end
    endtask

    task automatic test_redirect_hazard();
        clr_cnt();
        load_use(5'd5, 5'd5, 5'd0, 1, 0);
        ex_redirect = 1;
        #1;
        checks++; if (pc_sel !== 2'b01 || {if_stall, id_flush, ex_hold} !== 3'b010) begin errors++;
            $display("FAIL redirect_over_hazard: got pc_sel=%b flags=%b expected 01/010",
                     pc_sel, {if_stall, id_flush, ex_hold}); end
        cyc();
        idle();
        #1;
        checks++; if (instret_cnt !== 8'd1) begin errors++;
            $display("FAIL redirect_instret: got %0d expected 1", instret_cnt); end
    endtask

    task automatic test_mmio_wait();
        clr_cnt();
        ex_valid = 1; ex_mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (pc_sel !== 2'b11 || {if_stall, id_flush, ex_hold} !== 3'b101) begin
                errors++;
                $display("FAIL mmio_hold_%0d: got pc_sel=%b flags=%b expected 11/101",
                         i, pc_sel, {if_stall, id_flush, ex_hold});
            end
            cyc();
        end
        #1;
        checks++; if (instret_cnt !== 8'd0) begin errors++;
            $display("FAIL mmio_no_retire: got %0d expected 0", instret_cnt); end
        mem_ready = 1;
        #1;
        checks++; if (pc_sel !== 2'b00 || {if_stall, id_flush, ex_hold} !== 3'b000) begin errors++;
            $display("FAIL mmio_release: got pc_sel=%b flags=%b expected 00/000",
                     pc_sel, {if_stall, id_flush, ex_hold}); end
        cyc();
        idle();
        #1;
        checks++; if (instret_cnt !== 8'd1 || pc_sel !== 2'b00 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL mmio_back_to_run: got instret=%0d pc_sel=%b tmo=%b expected 1/00/0",
                     instret_cnt, pc_sel, mem_timeout);
        end
        // Held branch that also waits on MMIO: redirect lands in the release cycle.
        ex_valid = 1; ex_mem_req = 1; ex_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (pc_sel !== 2'b11 || ex_hold !== 1'b1) begin errors++;
                $display("FAIL mmio_redirect_hold_%0d: got pc_sel=%b hold=%b expected 11/1",
                         i, pc_sel, ex_hold); end
            cyc();
        end
        mem_ready = 1;
        #1;
        checks++; if (pc_sel !== 2'b01 || {if_stall, id_flush, ex_hold} !== 3'b010) begin errors++;
            $display("FAIL mmio_redirect_release: got pc_sel=%b flags=%b expected 01/010",
                     pc_sel, {if_stall, id_flush, ex_hold}); end
        cyc();
        idle();
        #1;
        checks++; if (instret_cnt !== 8'd2) begin errors++;
            $display("FAIL mmio_redirect_instret: got %0d expected 2", instret_cnt); end
    endtask

    task automatic test_timeout();
        int n;
        clr_cnt();
        ex_valid = 1; ex_mem_req = 1; mem_ready = 0;
        #1;
        checks++; if (ex_hold !== 1'b1) begin errors++;
            $display("FAIL timeout_enter: got hold=%b expected 1", ex_hold); end
        n = 0;
        cyc();
        #1;
        while (ex_hold === 1'b1 && n < 400) begin
            n++;
            cyc();
            #1;
        end
        checks++; if (n !== 255) begin errors++;
            $display("FAIL timeout_wait_cycles: got %0d expected 255", n); end
        checks++; if (pc_sel !== 2'b00 || mem_timeout !== 1'b0) begin errors++;
            $display("FAIL timeout_release: got pc_sel=%b tmo=%b expected 00/0", pc_sel, mem_timeout);
        end
        cyc();
        idle();
        #1;
        checks++; if (mem_timeout !== 1'b1 || instret_cnt !== 8'd1) begin errors++;
            $display("FAIL timeout_flag: got tmo=%b instret=%0d expected 1/1",
                     mem_timeout, instret_cnt); end
        repeat (3) cyc();
        #1;
        checks++; if (mem_timeout !== 1'b1) begin errors++;
            $display("FAIL timeout_sticky: got %b expected 1", mem_timeout); end
    endtask

    task automatic test_counters();
        clr_cnt();
        ex_valid = 1;
        repeat (255) cyc();
        #1;
        checks++; if (cycle_cnt !== 8'd255 || instret_cnt !== 8'd255) begin errors++;
            $display("FAIL cnt_max: got %0d/%0d expected 255/255", cycle_cnt, instret_cnt); end
        cyc();
        #1;
        checks++; if (cycle_cnt !== 8'd0 || instret_cnt !== 8'd0) begin errors++;
            $display("FAIL cnt_wrap: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt); end
        cyc();
        #1;
        checks++; if (cycle_cnt !== 8'd1 || instret_cnt !== 8'd1) begin errors++;
            $display("FAIL cnt_after_wrap: got %0d/%0d expected 1/1", cycle_cnt, instret_cnt); end
        cnt_reset = 1;
        cyc();
        idle();
        #1;
        checks++; if (cycle_cnt !== 8'd0 || instret_cnt !== 8'd0) begin errors++;
            $display("FAIL cnt_reset_with_retire: got %0d/%0d expected 0/0",
                     cycle_cnt, instret_cnt); end
    endtask

    task automatic test_mid_reset();
        ex_valid = 1; ex_mem_req = 1; mem_ready = 0;
        cyc();
        cyc();
        #1;
        checks++; if (ex_hold !== 1'b1) begin errors++;
            $display("FAIL mid_reset_setup: got hold=%b expected 1", ex_hold); end
        rst = 0;
        cyc();
        rst = 1;
        idle();
        #1;
        checks++; if (cycle_cnt !== 8'd0 || instret_cnt !== 8'd0 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_regs: got %0d/%0d/%b expected 0/0/0",
                     cycle_cnt, instret_cnt, mem_timeout);
        end
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (pc_sel !== 2'b10) begin errors++;
                $display("FAIL mid_reset_boot_%0d: got %b expected 10", i, pc_sel); end
            cyc();
        end
        #1;
        checks++; if (pc_sel !== 2'b00 || cycle_cnt !== 8'd4) begin errors++;
            $display("FAIL mid_reset_run: got pc_sel=%b cycle=%0d expected 00/4", pc_sel, cycle_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect_hazard();
        test_mmio_wait();
        test_timeout();
        test_counters();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
